// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline registers.
// Every stage instance (IF/ID, ID/EX, EX/MEM, MEM/WB) takes its defaults from here,
// so a width change is made in one place.
package pipe_pkg;

    // The state encoding is also the occupancy count that the stage reports.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    localparam int CTRL_W_ID_EX = 8;
    localparam int DATA_W_ID_EX = 96;
    localparam int KEEP_W       = 64;
    localparam int CNT_W_DEF    = 16;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the pipeline stage statistics.
// It sticks at all-ones instead of wrapping, so a long stall cannot read back as a short one.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset, clears count
//   clear  in   synchronous clear (wins over inc)
//   inc    in   count this cycle
//   count  out  current value, CNT_W bits
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with a valid/ready handshake, a 2-entry skid
// buffer and a synchronous flush.
//   - Main entry drives out_*; the skid entry catches the one input accepted while the
//     downstream stalls. in_ready depends only on registered state, so there is no
//     combinational path from out_ready to in_ready.
//   - Flush empties the stage: ctrl/data are bubbled to zero, out_keep loads in_keep so
//     the trace still shows the squashed slot. A fire in the flush cycle still completes.
// Optional build macro: PIPE_STAGE_STATS_EN adds the CNT_W parameter and the stall_cnt /
// flush_cnt saturating counters; without it neither ports nor counter flops exist.
// Ports:
//   clock, reset (async active-low), flush (sync)
//   in_valid / in_ready / in_ctrl / in_data / in_keep      upstream side
//   out_valid / out_ready / out_ctrl / out_data / out_keep upstream side of the next stage
//   occupancy   number of held entries (0..2)
//   stall_cnt   cycles with out_valid & ~out_ready            (stats build only)
//   flush_cnt   flush cycles that killed at least one entry   (stats build only)
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_ID_EX,
    parameter int DATA_W = DATA_W_ID_EX,
    parameter int KEEP_W = pipe_pkg::KEEP_W
`ifdef PIPE_STAGE_STATS_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);

    occ_state_e        state;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [KEEP_W-1:0] skid_keep;
    logic              acc;
    logic              fire;

    // Main is valid in ONE and TWO; skid is valid only in TWO.
    assign out_valid = (state != OCC_EMPTY);
    assign in_ready  = (state != OCC_TWO);
    assign occupancy = state;
    assign acc       = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= OCC_EMPTY;
            out_ctrl  <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_keep <= '0;
        end else if (flush) begin
            // Any accepted input this cycle is swallowed along with the held entries.
            state     <= OCC_EMPTY;
            out_ctrl  <= '0;
            out_data  <= '0;
            out_keep  <= in_keep;
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_keep <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (acc) begin
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                        out_keep <= in_keep;
                        state    <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (acc && fire) begin
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                        out_keep <= in_keep;
                    end else if (fire) begin
                        state <= OCC_EMPTY;
                    end else if (acc) begin
                        // Downstream stalled: park the newer entry behind main.
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        skid_keep <= in_keep;
                        state     <= OCC_TWO;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so only the skid entry can advance.
                    if (fire) begin
                        out_ctrl <= skid_ctrl;
                        out_data <= skid_data;
                        out_keep <= skid_keep;
                        state    <= OCC_ONE;
                    end
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    // Only flushes that actually squash a held entry are counted.
    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (flush & out_valid),
        .count (flush_cnt)
    );
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid.
// Inputs change 1 time unit after the rising edge; outputs are checked in the same window.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CW = 8;
    localparam int DW = 96;
    localparam int KW = 64;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic [KW-1:0] in_keep;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [KW-1:0] out_keep;
    logic [1:0]    occupancy;

    int n_run;
    int n_fail;

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [KW-1:0] s_out_keep;
    logic [1:0]    s_occupancy;
    logic [1:0]    s_stall_cnt;
    logic [1:0]    s_flush_cnt;
`endif

    pipe_stage_skid #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .KEEP_W (KW)
`ifdef PIPE_STAGE_STATS_EN
        , .CNT_W (16)
`endif
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt (stall_cnt)
        , .flush_cnt (flush_cnt)
`endif
    );

`ifdef PIPE_STAGE_STATS_EN
    // Narrow-counter copy fed identical stimulus, to see saturation at 2'b11.
    pipe_stage_skid #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .KEEP_W (KW),
        .CNT_W  (2)
    ) u_sat (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_ctrl  (s_out_ctrl),
        .out_data  (s_out_data),
        .out_keep  (s_out_keep),
        .occupancy (s_occupancy),
        .stall_cnt (s_stall_cnt),
        .flush_cnt (s_flush_cnt)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic [KW-1:0] k);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
        in_keep  = k;
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        #3 reset = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_occ",       occupancy, 2'd0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_data",  out_data,  '0);
        reset = 1'b1;
        tick();

        // Reset while two entries are held.
        drive(1'b1, 8'h11, 96'h11, 64'h11);
        tick();
        drive(1'b1, 8'h22, 96'h22, 64'h22);
        tick();
        chk("t1_occ_full", occupancy, 2'd2);
        drive(1'b0, '0, '0, '0);
        reset = 1'b0;
        #1;
        chk("t1_async_occ", occupancy, 2'd0);
        tick();
        chk("t1_out_valid", out_valid, 1'b0);
        chk("t1_occ",       occupancy, 2'd0);
        chk("t1_in_ready",  in_ready,  1'b1);
        chk("t1_out_ctrl",  out_ctrl,  '0);
        chk("t1_out_data",  out_data,  '0);
        chk("t1_out_keep",  out_keep,  '0);
        reset = 1'b1;
        tick();

`ifdef PIPE_STAGE_STATS_EN
        // Five stall cycles, then a flush on an occupied stage and one on an empty stage.
        drive(1'b1, 8'h5A, 96'h5A, 64'h5A);
        tick();
        drive(1'b0, '0, '0, '0);
        tick();
        tick();
        chk("t6_stall_2",     stall_cnt,   16'd2);
        chk("t6_sat_stall_2", s_stall_cnt, 2'd2);
        tick();
        tick();
        tick();
        chk("t6_stall_5",     stall_cnt,   16'd5);
        chk("t6_sat_stall",   s_stall_cnt, 2'd3);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        chk("t6_flush_1", flush_cnt, 16'd1);
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("t6_flush_empty", flush_cnt, 16'd1);
        chk("t6_stall_final", stall_cnt, 16'd5);
        tick();
`endif

        // Streaming with no back-pressure: one cycle latency, order kept, never more than one held.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, CW'(i), DW'(i), KW'(i));
            tick();
            chk($sformatf("t2_data_%0d", i), out_data, 128'(i));
            chk($sformatf("t2_occ_%0d", i),  occupancy, 2'd1);
        end
        drive(1'b0, '0, '0, '0);
        tick();
        chk("t2_drain_valid", out_valid, 1'b0);

        // Back-pressure: A, B fill the stage, C waits upstream.
        out_ready = 1'b0;
        drive(1'b1, 8'hA, 96'hA, 64'hA);
        tick();
        drive(1'b1, 8'hB, 96'hB, 64'hB);
        tick();
        chk("t3_occ_2",      occupancy, 2'd2);
        chk("t3_in_ready_0", in_ready,  1'b0);
        chk("t3_head_A",     out_data,  96'hA);
        drive(1'b1, 8'hC, 96'hC, 64'hC);
        tick();
        chk("t3_hold_A",   out_data,  96'hA);
        chk("t3_hold_occ", occupancy, 2'd2);
        out_ready = 1'b1;
        tick();
        chk("t3_B",     out_data,  96'hB);
        chk("t3_B_key", out_keep,  64'hB);
        chk("t3_B_occ", occupancy, 2'd1);
        // ONE with acc and fire together: C replaces B, occupancy stays at one.
        chk("t5_in_ready_pre", in_ready, 1'b1);
        tick();
        chk("t5_C",             out_data,  96'hC);
        chk("t5_C_ctrl",        out_ctrl,  8'hC);
        chk("t5_occ",           occupancy, 2'd1);
        chk("t5_in_ready_post", in_ready,  1'b1);
        drive(1'b0, '0, '0, '0);
        tick();
        chk("t3_empty", out_valid, 1'b0);

        // Flush on a full stage with a concurrent input.
        out_ready = 1'b0;
        drive(1'b1, 8'h31, 96'h31, 64'h31);
        tick();
        drive(1'b1, 8'h32, 96'h32, 64'h32);
        tick();
        chk("t4_occ_full", occupancy, 2'd2);
        flush = 1'b1;
        drive(1'b1, 8'h7F, 96'hFFFF, 64'h00400010_8C220004);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("t4_out_valid", out_valid, 1'b0);
        chk("t4_out_ctrl",  out_ctrl,  '0);
        chk("t4_out_data",  out_data,  '0);
        chk("t4_out_keep",  out_keep,  64'h00400010_8C220004);
        chk("t4_occ",       occupancy, 2'd0);
        tick();
        chk("t4_occ_after", occupancy, 2'd0);
        chk("t4_in_ready",  in_ready,  1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_skid
